icache: RTL and testbench

- Direct-mapped instruction cache between ifetch (upstream requester) and the memory controller (downstream byte-serial refill engine).
- Serves ifetch PC lookups with a registered hit response.
- On a miss, drives a held refill request to the memory controller, captures the returned 32-bit word and writes it into the array.
- Forwards the word to ifetch.

---
 rtl/icache.sv | 141 ++++++++++++++
 tb/tb_icache.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache with byte-serial memory refill.
// Define ICACHE_C_PREFILL_EN to also fill the slot of PC+2 from compressed refills.
module icache #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INST_WIDTH  = 32,
   parameter int INDEX_WIDTH = 4,
   parameter int TAG_WIDTH   = 27
) (
   input  logic                   clk,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   input  logic                   flush,
   input  logic                   if2cache_en,
   input  logic [ADDR_WIDTH-1:0]  if2cache_PC,
   output logic                   cache2if_rdy,
   output logic [INST_WIDTH-1:0]  cache2if_inst,
   output logic                   cache2if_busy,
   output logic                   cache2mem_upd_en,
   output logic [ADDR_WIDTH-1:0]  cache2mem_PC,
   input  logic                   mem2cache_upd,
   input  logic [INDEX_WIDTH-1:0] mem2cache_idx,
   input  logic [TAG_WIDTH-1:0]   mem2cache_tag,
   input  logic [ADDR_WIDTH-1:0]  mem2cache_PC,
   input  logic [INST_WIDTH-1:0]  mem2if_inst_out,
   input  logic                   is_c_inst,
   input  logic [TAG_WIDTH-1:0]   sec_inst_tag,
   input  logic [INDEX_WIDTH-1:0] sec_inst_index
);

   localparam int DEPTH = 1 << INDEX_WIDTH;

   typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;

   state_t state_q, state_d;

   logic [DEPTH-1:0]      valid_q;
   logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
   logic [INST_WIDTH-1:0] data_q [DEPTH];

   logic [INDEX_WIDTH-1:0] req_idx;
   logic [TAG_WIDTH-1:0]   req_tag;
   logic                   hit;
   logic                   lookup;
   logic                   fill;

   assign req_idx = if2cache_PC[INDEX_WIDTH:1];
   assign req_tag = if2cache_PC[INDEX_WIDTH+TAG_WIDTH:INDEX_WIDTH+1];
   assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign lookup  = (state_q == IDLE) && if2cache_en && !flush;
   assign fill    = (state_q == MISS) && mem2cache_upd
                    && (mem2cache_PC == cache2mem_PC);

   always_ff @(posedge clk) begin
      if (!rst_in) begin
         state_q <= IDLE;
      end else if (rdy_in) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (if2cache_en) state_d = hit ? RESP : MISS;
            MISS:    if (fill) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      cache2if_rdy     = 1'b0;
      cache2if_busy    = 1'b0;
      cache2mem_upd_en = 1'b0;
      unique case (state_q)
         MISS: begin
            cache2if_busy    = 1'b1;
            cache2mem_upd_en = 1'b1;
         end
         RESP: begin
            cache2if_busy = 1'b1;
            cache2if_rdy  = 1'b1;
         end
         default: ;
      endcase
   end

   // Response word and refill PC only move on the events that own them.
   always_ff @(posedge clk) begin
      if (!rst_in) begin
         cache2if_inst <= '0;
         cache2mem_PC  <= '0;
      end else if (rdy_in) begin
         if (lookup && hit) cache2if_inst <= data_q[req_idx];
         if (fill && !flush) cache2if_inst <= mem2if_inst_out;
         if (lookup && !hit) cache2mem_PC <= if2cache_PC;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_in) begin
         valid_q <= '0;
      end else if (rdy_in && fill) begin
`ifdef ICACHE_C_PREFILL_EN
         if (is_c_inst && mem2if_inst_out[17:16] != 2'b11) begin
            valid_q[sec_inst_index] <= 1'b1;
         end
`endif
         valid_q[mem2cache_idx] <= 1'b1;
      end
   end

   // Primary write is issued last so it wins on an index collision.
   always_ff @(posedge clk) begin
      if (rst_in && rdy_in && fill) begin
`ifdef ICACHE_C_PREFILL_EN
         if (is_c_inst && mem2if_inst_out[17:16] != 2'b11) begin
            tag_q[sec_inst_index]  <= sec_inst_tag;
            data_q[sec_inst_index] <= {{(INST_WIDTH-16){1'b0}},
                                       mem2if_inst_out[31:16]};
         end
`endif
         tag_q[mem2cache_idx]  <= mem2cache_tag;
         data_q[mem2cache_idx] <= mem2if_inst_out;
      end
   end

`ifdef ICACHE_C_PREFILL_EN
   logic unused_pc0;
   assign unused_pc0 = if2cache_PC[0];
`else
   logic unused_sec;
   assign unused_sec = ^{is_c_inst, sec_inst_tag, sec_inst_index,
                         if2cache_PC[0]};
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: vector table, hand sequences and
// randomized requests against a slot-level reference model.
module tb_icache;

   logic        clk = 1'b0;
   logic        rst_in, rdy_in, flush;
   logic        if2cache_en;
   logic [31:0] if2cache_PC;
   logic        cache2if_rdy;
   logic [31:0] cache2if_inst;
   logic        cache2if_busy;
   logic        cache2mem_upd_en;
   logic [31:0] cache2mem_PC;
   logic        mem2cache_upd;
   logic [3:0]  mem2cache_idx;
   logic [26:0] mem2cache_tag;
   logic [31:0] mem2cache_PC;
   logic [31:0] mem2if_inst_out;
   logic        is_c_inst;
   logic [26:0] sec_inst_tag;
   logic [3:0]  sec_inst_index;

   int checks = 0;
   int errors = 0;

   bit          ref_v  [16];
   logic [31:0] ref_pc [16];
   logic [31:0] ref_w  [16];

   typedef struct {
      logic [31:0] pc;
      int          lat;
      bit          hit;
      logic [31:0] inst;
   } vec_t;

   vec_t tbl [9];

   always #5 clk = ~clk;

   icache dut (
      .clk              (clk),
      .rst_in           (rst_in),
      .rdy_in           (rdy_in),
      .flush            (flush),
      .if2cache_en      (if2cache_en),
      .if2cache_PC      (if2cache_PC),
      .cache2if_rdy     (cache2if_rdy),
      .cache2if_inst    (cache2if_inst),
      .cache2if_busy    (cache2if_busy),
      .cache2mem_upd_en (cache2mem_upd_en),
      .cache2mem_PC     (cache2mem_PC),
      .mem2cache_upd    (mem2cache_upd),
      .mem2cache_idx    (mem2cache_idx),
      .mem2cache_tag    (mem2cache_tag),
      .mem2cache_PC     (mem2cache_PC),
      .mem2if_inst_out  (mem2if_inst_out),
      .is_c_inst        (is_c_inst),
      .sec_inst_tag     (sec_inst_tag),
      .sec_inst_index   (sec_inst_index)
   );

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // Backing memory contents as a pure function of PC.
   function automatic logic [31:0] mem_word(logic [31:0] pc);
      case (pc)
         32'h4:   return 32'h00A00093;
         32'h10:  return 32'h45014505;
         32'h40:  return 32'h00100013;
         default: return (pc * 32'h9E3779B1) ^ 32'h12345678;
      endcase
   endfunction

   function automatic int slot(logic [31:0] pc);
      return int'((pc >> 1) % 16);
   endfunction

   function automatic void model_fill(logic [31:0] pc, logic [31:0] w);
`ifdef ICACHE_C_PREFILL_EN
      if (w[1:0] != 2'b11 && w[17:16] != 2'b11) begin
         ref_v[slot(pc + 2)]  = 1'b1;
         ref_pc[slot(pc + 2)] = pc + 2;
         ref_w[slot(pc + 2)]  = {16'h0, w[31:16]};
      end
`endif
      ref_v[slot(pc)]  = 1'b1;
      ref_pc[slot(pc)] = pc;
      ref_w[slot(pc)]  = w;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 16; i++) ref_v[i] = 1'b0;
   endfunction

   function automatic bit model_hit(logic [31:0] pc);
      return ref_v[slot(pc)] && ref_pc[slot(pc)] == pc;
   endfunction

   // Memory completion pulse for pc, held for one cycle.
   task automatic mem_pulse(input logic [31:0] pc);
      logic [31:0] w, pc2;
      w               = mem_word(pc);
      pc2             = pc + 2;
      mem2cache_upd   = 1'b1;
      mem2cache_PC    = pc;
      mem2cache_idx   = pc[4:1];
      mem2cache_tag   = pc[31:5];
      mem2if_inst_out = w;
      is_c_inst       = (w[1:0] != 2'b11);
      sec_inst_index  = pc2[4:1];
      sec_inst_tag    = pc2[31:5];
      @(negedge clk);
      mem2cache_upd   = 1'b0;
      mem2if_inst_out = $urandom;
   endtask

   task automatic issue(input logic [31:0] pc);
      @(negedge clk);
      if2cache_en = 1'b1;
      if2cache_PC = pc;
      @(negedge clk);
      if2cache_en = 1'b0;
      if2cache_PC = $urandom;
   endtask

   task automatic do_req(input logic [31:0] pc, input int lat,
                         input bit exp_hit, input logic [31:0] exp_inst,
                         input string nm);
      bit held;
      issue(pc);
      chk({nm, " path"}, {30'd0, cache2if_rdy, cache2mem_upd_en},
          exp_hit ? 32'd2 : 32'd1);
      if (!cache2if_rdy && cache2mem_upd_en) begin
         held = 1'b1;
         chk({nm, " mem_pc"}, cache2mem_PC, pc);
         for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            if (!(cache2mem_upd_en && cache2mem_PC == pc && !cache2if_rdy))
               held = 1'b0;
         end
         chk({nm, " held"}, {31'd0, held}, 32'd1);
         mem_pulse(pc);
         model_fill(pc, mem_word(pc));
      end
      chk({nm, " rdy"}, {31'd0, cache2if_rdy}, 32'd1);
      chk({nm, " inst"}, cache2if_inst, exp_inst);
      @(negedge clk);
      chk({nm, " after"},
          {29'd0, cache2if_rdy, cache2mem_upd_en, cache2if_busy}, 32'd0);
   endtask

   task automatic req_model(input logic [31:0] pc, input int lat,
                            input string nm);
      bit h;
      h = model_hit(pc);
      do_req(pc, lat, h, h ? ref_w[slot(pc)] : mem_word(pc), nm);
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, " rdy"}, {31'd0, cache2if_rdy}, 32'd0);
      chk({nm, " inst"}, cache2if_inst, 32'd0);
      chk({nm, " upd_en"}, {31'd0, cache2mem_upd_en}, 32'd0);
      chk({nm, " mem_pc"}, cache2mem_PC, 32'd0);
      chk({nm, " busy"}, {31'd0, cache2if_busy}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_in = 1'b0; rdy_in = 1'b0; flush = 1'b0;
      if2cache_en = 1'b0; if2cache_PC = '0;
      mem2cache_upd = 1'b0; mem2cache_idx = '0; mem2cache_tag = '0;
      mem2cache_PC = '0; mem2if_inst_out = '0; is_c_inst = 1'b0;
      sec_inst_tag = '0; sec_inst_index = '0;
      model_clear();

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_in = 1'b1;
      rdy_in = 1'b1;

      tbl[0] = '{32'h04, 5, 1'b0, 32'h00A00093};
      tbl[1] = '{32'h04, 1, 1'b1, 32'h00A00093};
      tbl[2] = '{32'h24, 3, 1'b0, mem_word(32'h24)};
      tbl[3] = '{32'h04, 2, 1'b0, 32'h00A00093};
      tbl[4] = '{32'h10, 4, 1'b0, 32'h45014505};
`ifdef ICACHE_C_PREFILL_EN
      tbl[5] = '{32'h12, 2, 1'b1, 32'h00004501};
`else
      tbl[5] = '{32'h12, 2, 1'b0, mem_word(32'h12)};
`endif
      tbl[6] = '{32'hFFFFFFFE, 1, 1'b0, mem_word(32'hFFFFFFFE)};
      tbl[7] = '{32'hFFFFFFFE, 1, 1'b1, mem_word(32'hFFFFFFFE)};
      tbl[8] = '{32'h10, 1, 1'b1, 32'h45014505};

      for (int i = 0; i < 9; i++)
         do_req(tbl[i].pc, tbl[i].lat, tbl[i].hit, tbl[i].inst,
                $sformatf("vec%0d", i));

      // Flush two cycles into a miss; a late completion must stay silent.
      issue(32'h40);
      chk("flush_a upd_en", {31'd0, cache2mem_upd_en}, 32'd1);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_a upd_off", {31'd0, cache2mem_upd_en}, 32'd0);
      chk("flush_a busy", {31'd0, cache2if_busy}, 32'd0);
      chk("flush_a rdy", {31'd0, cache2if_rdy}, 32'd0);
      mem_pulse(32'h40);
      chk("flush_a late0", {31'd0, cache2if_rdy}, 32'd0);
      @(negedge clk);
      chk("flush_a late1", {31'd0, cache2if_rdy}, 32'd0);
      req_model(32'h60, 2, "flush_a next");

      // Flush coinciding with completion: array written, no response.
      issue(32'h08);
      @(negedge clk);
      flush = 1'b1;
      mem_pulse(32'h08);
      flush = 1'b0;
      model_fill(32'h08, mem_word(32'h08));
      chk("flush_b rdy0", {31'd0, cache2if_rdy}, 32'd0);
      chk("flush_b upd", {31'd0, cache2mem_upd_en}, 32'd0);
      @(negedge clk);
      chk("flush_b rdy1", {31'd0, cache2if_rdy}, 32'd0);
      do_req(32'h08, 1, 1'b1, ref_w[slot(32'h08)], "flush_b hit");

      // Reset while stalled clears every valid bit.
      rst_in = 1'b0;
      rdy_in = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset2");
      rst_in = 1'b1;
      rdy_in = 1'b1;
      model_clear();
      do_req(32'h04, 2, 1'b0, 32'h00A00093, "post_reset");

      // Stall for three cycles in the middle of a miss.
      issue(32'h7A);
      chk("stall upd_en", {31'd0, cache2mem_upd_en}, 32'd1);
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("stall%0d upd", i), {31'd0, cache2mem_upd_en}, 32'd1);
         chk($sformatf("stall%0d pc", i), cache2mem_PC, 32'h7A);
         chk($sformatf("stall%0d rdy", i), {31'd0, cache2if_rdy}, 32'd0);
      end
      rdy_in = 1'b1;
      mem_pulse(32'h7A);
      model_fill(32'h7A, mem_word(32'h7A));
      chk("stall rdy", {31'd0, cache2if_rdy}, 32'd1);
      chk("stall inst", cache2if_inst, mem_word(32'h7A));
      @(negedge clk);
      chk("stall after", {30'd0, cache2if_rdy, cache2mem_upd_en}, 32'd0);

      for (int i = 0; i < 200; i++)
         req_model(32'($urandom_range(0, 63)) << 1,
                   int'($urandom_range(1, 6)), $sformatf("rnd%0d", i));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
